// File: rtl/conv_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : conv_sample_feeder
//  Description : Single-entry sample buffer and issue sequencer feeding a
//                convolution controller. Issues one sample or one coefficient
//                load at a time, waits for the controller to go idle, and
//                tracks the row/column position of the next sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_sample_feeder (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic [7:0]  cfg_width,
    input  logic        coeff_req,
    input  logic        frame_start,
    input  logic        modwait,
    output logic        sample_load_en,
    output logic        new_row,
    output logic        coeff_load_en,
    output logic [15:0] sample_data,
    output logic [7:0]  col_count,
    output logic [15:0] row_count
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_COEFF     = 3'd2;
    localparam logic [2:0] ST_WAIT1     = 3'd3;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd4;

    localparam logic [7:0] MIN_WIDTH    = 8'd3;

    logic [2:0]  state_q, state_d;
    logic        buf_full_q, buf_full_d;
    logic [15:0] buf_data_q, buf_data_d;
    logic        coeff_pend_q, coeff_pend_d;
    logic        frame_pend_q, frame_pend_d;
    logic [7:0]  col_q, col_d;
    logic [15:0] row_q, row_d;

    logic [7:0]  eff_width;
    logic        last_col;
    logic        accept;

    // Widths below three collapse to three; ">=" keeps the column counter
    // bounded even if the width is lowered mid-row.
    assign eff_width = (cfg_width < MIN_WIDTH) ? MIN_WIDTH : cfg_width;
    assign last_col  = (col_q >= (eff_width - 8'd1));

    // Ready is held low combinationally while reset is asserted.
    assign in_ready  = n_rst & ~buf_full_q;
    assign accept    = in_valid & in_ready;

    assign sample_data = buf_data_q;
    assign col_count   = col_q;
    assign row_count   = row_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a pending coefficient load wins over a buffered sample.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (coeff_pend_q && !modwait) begin
                    state_d = ST_COEFF;
                end else if (buf_full_q && !modwait) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE:     state_d = ST_WAIT1;
            ST_COEFF:     state_d = ST_WAIT1;
            ST_WAIT1:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!modwait) begin
                    state_d = ST_IDLE;
                end
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    // Moore output decode; the two strobes come from distinct states.
    always_comb begin
        sample_load_en = 1'b0;
        coeff_load_en  = 1'b0;
        new_row        = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                sample_load_en = 1'b1;
                new_row        = (col_q == 8'd0) && (row_q != 16'd0);
            end
            ST_COEFF: coeff_load_en = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: buffer, pending flags and position counters.
    always_comb begin
        buf_full_d   = buf_full_q;
        buf_data_d   = buf_data_q;
        coeff_pend_d = coeff_pend_q;
        frame_pend_d = frame_pend_q;
        col_d        = col_q;
        row_d        = row_q;

        // Buffer empties as the sample is issued; refills whenever empty.
        if (state_q == ST_ISSUE) begin
            buf_full_d = 1'b0;
        end
        if (accept) begin
            buf_full_d = 1'b1;
            buf_data_d = in_data;
        end

        // Leaving COEFF retires the request; repeats while pending merge.
        if (state_q == ST_COEFF) begin
            coeff_pend_d = 1'b0;
        end else if (coeff_req) begin
            coeff_pend_d = 1'b1;
        end

        // Position advances as each sample leaves ISSUE; row wraps naturally.
        if (state_q == ST_ISSUE) begin
            if (last_col) begin
                col_d = 8'd0;
                row_d = row_q + 16'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end

        // Frame restart only touches the counters from IDLE; otherwise it
        // is remembered until the sequencer next rests in IDLE.
        if (state_q == ST_IDLE) begin
            if (frame_start || frame_pend_q) begin
                col_d        = 8'd0;
                row_d        = 16'd0;
                frame_pend_d = 1'b0;
            end
        end else if (frame_start) begin
            frame_pend_d = 1'b1;
        end
    end

    // Datapath registers; reset discards any buffered sample.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            buf_full_q   <= 1'b0;
            buf_data_q   <= 16'd0;
            coeff_pend_q <= 1'b0;
            frame_pend_q <= 1'b0;
            col_q        <= 8'd0;
            row_q        <= 16'd0;
        end else begin
            buf_full_q   <= buf_full_d;
            buf_data_q   <= buf_data_d;
            coeff_pend_q <= coeff_pend_d;
            frame_pend_q <= frame_pend_d;
            col_q        <= col_d;
            row_q        <= row_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_sample_feeder
//  Description : Self-checking bench for conv_sample_feeder: a cycle-by-cycle
//                vector table plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_sample_feeder;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [7:0]  cfg_width;
    logic        coeff_req;
    logic        frame_start;
    logic        modwait;
    logic        sample_load_en;
    logic        new_row;
    logic        coeff_load_en;
    logic [15:0] sample_data;
    logic [7:0]  col_count;
    logic [15:0] row_count;

    int n_cmp  = 0;
    int n_fail = 0;

    conv_sample_feeder dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .cfg_width      (cfg_width),
        .coeff_req      (coeff_req),
        .frame_start    (frame_start),
        .modwait        (modwait),
        .sample_load_en (sample_load_en),
        .new_row        (new_row),
        .coeff_load_en  (coeff_load_en),
        .sample_data    (sample_data),
        .col_count      (col_count),
        .row_count      (row_count)
    );

    always #5 clk = ~clk;

    // Outputs must never strobe both loads together.
    always @(negedge clk) begin
        if (sample_load_en && coeff_load_en) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL strobe_overlap: sample_load_en=1 coeff_load_en=1 at %0t", $time);
        end
    end

    typedef struct {
        logic        rst;
        logic        v;
        logic [15:0] d;
        logic        cr;
        logic        fs;
        logic        mw;
        logic        rdy;
        logic        sle;
        logic        cle;
        logic        nr;
        logic [15:0] sd;
        logic [7:0]  col;
        logic [15:0] row;
    } vec_t;

    localparam int NVEC = 27;
    vec_t tbl [NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        n_rst       = 1'b0;
        in_valid    = 1'b0;
        coeff_req   = 1'b0;
        frame_start = 1'b0;
        modwait     = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    // Tick until a sample strobe appears or the budget runs out.
    task automatic wait_strobe(input string name, input int budget);
        int k;
        k = 0;
        tick();
        while (!sample_load_en && k < budget) begin
            tick();
            k++;
        end
        chk({name, ".strobe"}, sample_load_en, 1'b1);
    endtask

    // From IDLE with an empty buffer: present one word and wait for its strobe.
    task automatic feed(input string name, input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        wait_strobe(name, 8);
    endtask

    initial begin
        // rst v d cr fs mw | rdy sle cle nr sd col row
        tbl[0]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0000,8'd0,16'd0};
        tbl[1]  = '{1'b0,1'b1,16'h1234,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0000,8'd0,16'd0};
        tbl[2]  = '{1'b1,1'b1,16'h00A5,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h00A5,8'd0,16'd0};
        tbl[3]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,16'h00A5,8'd0,16'd0};
        tbl[4]  = '{1'b1,1'b1,16'h0011,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,16'h00A5,8'd1,16'd0};
        tbl[5]  = '{1'b1,1'b1,16'h0011,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,16'h0011,8'd1,16'd0};
        tbl[6]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,16'h0011,8'd1,16'd0};
        tbl[7]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0011,8'd1,16'd0};
        tbl[8]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,16'h0011,8'd1,16'd0};
        tbl[9]  = '{1'b1,1'b1,16'h0022,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,16'h0011,8'd2,16'd0};
        tbl[10] = '{1'b1,1'b1,16'h0022,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0022,8'd2,16'd0};
        tbl[11] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0022,8'd2,16'd0};
        tbl[12] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,16'h0022,8'd2,16'd0};
        tbl[13] = '{1'b1,1'b1,16'h0033,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,16'h0022,8'd0,16'd1};
        tbl[14] = '{1'b1,1'b1,16'h0033,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0033,8'd0,16'd1};
        tbl[15] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0033,8'd0,16'd1};
        tbl[16] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,16'h0033,8'd0,16'd1};
        tbl[17] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,16'h0033,8'd1,16'd1};
        tbl[18] = '{1'b1,1'b1,16'h0044,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0044,8'd1,16'd1};
        tbl[19] = '{1'b1,1'b0,16'h0000,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0044,8'd1,16'd1};
        tbl[20] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,16'h0044,8'd1,16'd1};
        tbl[21] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0044,8'd1,16'd1};
        tbl[22] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,16'h0044,8'd1,16'd1};
        tbl[23] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,16'h0044,8'd1,16'd1};
        tbl[24] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0044,8'd1,16'd1};
        tbl[25] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,16'h0044,8'd1,16'd1};
        tbl[26] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,16'h0044,8'd2,16'd1};

        n_rst       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 16'h0000;
        cfg_width   = 8'd3;
        coeff_req   = 1'b0;
        frame_start = 1'b0;
        modwait     = 1'b0;
        #2;

        // Cycle-by-cycle table: reset, first-sample latency, row wrap, coeff priority.
        for (int i = 0; i < NVEC; i++) begin
            n_rst       = tbl[i].rst;
            in_valid    = tbl[i].v;
            in_data     = tbl[i].d;
            coeff_req   = tbl[i].cr;
            frame_start = tbl[i].fs;
            modwait     = tbl[i].mw;
            tick();
            chk($sformatf("v%0d.in_ready", i),       in_ready,       tbl[i].rdy);
            chk($sformatf("v%0d.sample_load_en", i), sample_load_en, tbl[i].sle);
            chk($sformatf("v%0d.coeff_load_en", i),  coeff_load_en,  tbl[i].cle);
            chk($sformatf("v%0d.new_row", i),        new_row,        tbl[i].nr);
            chk($sformatf("v%0d.sample_data", i),    sample_data,    tbl[i].sd);
            chk($sformatf("v%0d.col_count", i),      col_count,      tbl[i].col);
            chk($sformatf("v%0d.row_count", i),      row_count,      tbl[i].row);
        end

        // Long modwait: no strobe while busy, second word buffered meanwhile.
        do_reset();
        cfg_width = 8'd3;
        feed("busy1", 16'hA001);
        chk("busy1.data", sample_data, 16'hA001);
        modwait  = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hA002;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("busy.hold%0d", k), sample_load_en, 1'b0);
        end
        in_valid = 1'b0;
        chk("busy.in_ready_full", in_ready, 1'b0);
        chk("busy.buffered", sample_data, 16'hA002);
        modwait = 1'b0;
        wait_strobe("busy2", 6);
        chk("busy2.data", sample_data, 16'hA002);
        chk("busy2.col", col_count, 8'd1);
        chk("busy2.row", row_count, 16'd0);

        // Reset while waiting on the controller with a full buffer.
        tick();
        modwait  = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hB00B;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst.full_before", in_ready, 1'b0);
        n_rst = 1'b0;
        tick();
        chk("rst.in_ready_low", in_ready, 1'b0);
        chk("rst.no_strobe", sample_load_en, 1'b0);
        chk("rst.data_cleared", sample_data, 16'h0000);
        chk("rst.col_cleared", col_count, 8'd0);
        n_rst   = 1'b1;
        modwait = 1'b0;
        #1;
        chk("rst.in_ready_high", in_ready, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rst.discard%0d", k), sample_load_en | coeff_load_en, 1'b0);
        end

        // Undersized width behaves as three; reach row 5 then restart the frame mid-wait.
        do_reset();
        cfg_width = 8'd0;
        for (int i = 0; i < 16; i++) begin
            feed($sformatf("frm%0d", i), 16'(i + 16'h0100));
            chk($sformatf("frm%0d.data", i), sample_data, 16'(i + 16'h0100));
            chk($sformatf("frm%0d.col", i), col_count, 8'(i % 3));
            chk($sformatf("frm%0d.row", i), row_count, 16'(i / 3));
            chk($sformatf("frm%0d.new_row", i), new_row, ((i % 3) == 0 && i >= 3) ? 1'b1 : 1'b0);
            if (i < 15) begin
                tick();
                tick();
                tick();
            end
        end
        modwait = 1'b1;
        tick();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("frm.held_col", col_count, 8'd1);
        chk("frm.held_row", row_count, 16'd5);
        modwait = 1'b0;
        tick();
        tick();
        chk("frm.cleared_col", col_count, 8'd0);
        chk("frm.cleared_row", row_count, 16'd0);
        feed("frm_after", 16'hC0DE);
        chk("frm_after.new_row", new_row, 1'b0);
        chk("frm_after.col", col_count, 8'd0);
        chk("frm_after.row", row_count, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
